// File: rtl/garage_door_plant.sv
// garage_door_plant: behavioural door/actuator model for the garage controller.
// It integrates the up_m/dn_m motor commands into a door position and drives
// the up_max/dn_max limit switches back to the controller. Driving both motor
// commands at once is latched as a fault that only reset clears.
// Optional feature macro: GARAGE_OBSTRUCT_EN adds the obstruct input. While it
// is high during a close, the motor stalls: the position and the prescaler hold.
// There is no valid/ready handshake. Every input is a level that is sampled on
// each rising clk edge, and every output is a registered decode.
module garage_door_plant #(
  parameter int TRAVEL   = 8,
  parameter int STEP_DIV = 4,
  parameter int PW       = $clog2(TRAVEL + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          up_m,
  input  logic          dn_m,
`ifdef GARAGE_OBSTRUCT_EN
  input  logic          obstruct,
`endif
  output logic          up_max,
  output logic          dn_max,
  output logic [PW-1:0] position,
  output logic          moving,
  output logic          fault,
  output logic [1:0]    state_dbg
);

  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] TRAVEL_P = PW'(TRAVEL);
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPENING = 2'd1,
    CLOSING = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [DW-1:0] div_base;
  logic          stall;

  // Register the FSM, the position and the prescaler. Reset snaps the door closed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // Next state, then stepping keyed on the direction being entered this edge.
  // The edge that starts a move is counted as the first prescaler tick.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    div_cnt_d = '0;
    div_base  = '0;
`ifdef GARAGE_OBSTRUCT_EN
    stall     = obstruct;
`else
    stall     = 1'b0;
`endif

    if (state_q == FAULT) begin
      state_d = FAULT;
    end else if (up_m && dn_m) begin
      state_d = FAULT;
    end else if (up_m && (pos_q != TRAVEL_P)) begin
      state_d = OPENING;
    end else if (dn_m && (pos_q != '0)) begin
      state_d = CLOSING;
    end else begin
      state_d = IDLE;
    end

    // A partial step survives only while moving in the same direction.
    if ((state_d == OPENING) || (state_d == CLOSING)) begin
      div_base = (state_d == state_q) ? div_cnt_q : '0;
      if ((state_d == CLOSING) && stall) begin
        div_cnt_d = div_base;
      end else if (div_base == DIV_LAST) begin
        div_cnt_d = '0;
        pos_d     = (state_d == OPENING) ? (pos_q + 1'b1) : (pos_q - 1'b1);
      end else begin
        div_cnt_d = div_base + 1'b1;
      end
    end
  end

  // Output decodes come only from registers, never from the inputs.
  always_comb begin
    up_max    = (pos_q == TRAVEL_P);
    dn_max    = (pos_q == '0);
    position  = pos_q;
    moving    = (state_q == OPENING) || (state_q == CLOSING);
    fault     = (state_q == FAULT);
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_garage_door_plant.sv
// tb_garage_door_plant: a directed walk through the door scenarios, then
// randomized command runs. Every cycle is checked against a model that counts
// consecutive command edges.
module tb_garage_door_plant;

  localparam int TRAVEL   = 8;
  localparam int STEP_DIV = 4;
  localparam int PW       = $clog2(TRAVEL + 1);
  localparam int VW       = PW + 4;

  // Clock and reset
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          up_m = 1'b0;
  logic          dn_m = 1'b0;
  logic          obstruct = 1'b0;
  logic          up_max, dn_max, moving, fault;
  logic [PW-1:0] position;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  garage_door_plant #(.TRAVEL(TRAVEL), .STEP_DIV(STEP_DIV)) dut (
    .clk(clk),
    .reset(reset),
    .up_m(up_m),
    .dn_m(dn_m),
`ifdef GARAGE_OBSTRUCT_EN
    .obstruct(obstruct),
`endif
    .up_max(up_max),
    .dn_max(dn_max),
    .position(position),
    .moving(moving),
    .fault(fault),
    .state_dbg(state_dbg)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model. A move is a run of consecutive edges in one legal
  // direction. Every STEP_DIV-th edge of the run moves the door one step.
  int m_pos = 0;
  int m_cnt = 0;
  int m_dir = 0;
  bit m_fault = 1'b0;
  logic [VW-1:0] exp_q[$];

  function automatic void model_update();
    int want;
    bit obs;
`ifdef GARAGE_OBSTRUCT_EN
    obs = obstruct;
`else
    obs = 1'b0;
`endif
    if (reset) begin
      m_pos = 0; m_cnt = 0; m_dir = 0; m_fault = 1'b0;
    end else if (m_fault) begin
      m_dir = 0;
    end else if (up_m && dn_m) begin
      m_fault = 1'b1; m_dir = 0; m_cnt = 0;
    end else begin
      if (up_m && m_pos < TRAVEL) want = 1;
      else if (dn_m && m_pos > 0) want = -1;
      else want = 0;
      if (want != m_dir) m_cnt = 0;
      m_dir = want;
      if (want != 0 && !(want < 0 && obs)) begin
        m_cnt++;
        if (m_cnt == STEP_DIV) begin
          m_pos += want;
          m_cnt = 0;
        end
      end
    end
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {PW'(m_pos), (m_pos == TRAVEL), (m_pos == 0), (m_dir != 0), m_fault};
  endfunction

  // Driver: inputs change at the negedge, so the DUT and the model see the same
  // values at the posedge. Outputs are then read at the following negedge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; up_m = 1'b0; dn_m = 1'b0; obstruct = 1'b0;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk_cnt++; if (position !== '0) $display("FAIL reset_pos: got %0d want 0", position); else pass_cnt++;
    chk_cnt++; if (dn_max !== 1'b1) $display("FAIL reset_dn_max: got %b want 1", dn_max); else pass_cnt++;
    chk_cnt++; if (up_max !== 1'b0) $display("FAIL reset_up_max: got %b want 0", up_max); else pass_cnt++;
    chk_cnt++; if (moving !== 1'b0) $display("FAIL reset_moving: got %b want 0", moving); else pass_cnt++;
    chk_cnt++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault); else pass_cnt++;
    chk_cnt++; if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_dbg); else pass_cnt++;
  endtask

  task automatic test_open();
    int exp_pos;
    up_m = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      tick();
      exp_pos = (i / STEP_DIV > TRAVEL) ? TRAVEL : i / STEP_DIV;
      chk_cnt++;
      if (position !== PW'(exp_pos)) $display("FAIL open_pos edge %0d: got %0d want %0d", i, position, exp_pos);
      else pass_cnt++;
      if (i == 1) begin
        chk_cnt++; if (moving !== 1'b1) $display("FAIL open_moving_start: got %b want 1", moving); else pass_cnt++;
      end
      if (i == 3) begin
        chk_cnt++; if (dn_max !== 1'b1) $display("FAIL open_dn_max_before_step: got %b want 1", dn_max); else pass_cnt++;
      end
      if (i == 4) begin
        chk_cnt++; if (dn_max !== 1'b0) $display("FAIL open_dn_max_after_step: got %b want 0", dn_max); else pass_cnt++;
      end
      if (i == 32) begin
        chk_cnt++; if (up_max !== 1'b1) $display("FAIL open_up_max: got %b want 1", up_max); else pass_cnt++;
        chk_cnt++; if (moving !== 1'b1) $display("FAIL open_moving_at_limit: got %b want 1", moving); else pass_cnt++;
      end
      if (i == 33) begin
        chk_cnt++; if (moving !== 1'b0) $display("FAIL open_stop_held_cmd: got %b want 0", moving); else pass_cnt++;
        chk_cnt++; if (up_max !== 1'b1) $display("FAIL open_up_max_held: got %b want 1", up_max); else pass_cnt++;
      end
    end
    up_m = 1'b0;
    tick();
  endtask

  task automatic test_close_gap();
    dn_m = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_cnt++;
      if (position !== PW'(TRAVEL - i / STEP_DIV)) $display("FAIL close_pos edge %0d: got %0d want %0d", i, position, TRAVEL - i / STEP_DIV);
      else pass_cnt++;
    end
    dn_m = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_cnt++;
      if (position !== PW'(6) || moving !== 1'b0) $display("FAIL close_gap edge %0d: got pos %0d moving %b want pos 6 moving 0", i, position, moving);
      else pass_cnt++;
    end
    dn_m = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_cnt++;
      if (position !== PW'((i < 4) ? 6 : 5)) $display("FAIL close_restart edge %0d: got %0d want %0d", i, position, (i < 4) ? 6 : 5);
      else pass_cnt++;
    end
    repeat (8) tick();
    dn_m = 1'b0;
    tick();
    chk_cnt++; if (position !== PW'(3)) $display("FAIL close_to_3: got %0d want 3", position); else pass_cnt++;
  endtask

  task automatic test_fault();
    up_m = 1'b1; dn_m = 1'b1;
    tick();
    chk_cnt++; if (fault !== 1'b1) $display("FAIL fault_set: got %b want 1", fault); else pass_cnt++;
    chk_cnt++; if (position !== PW'(3) || moving !== 1'b0) $display("FAIL fault_freeze: got pos %0d moving %b want pos 3 moving 0", position, moving); else pass_cnt++;
    up_m = 1'b0; dn_m = 1'b0;
    repeat (3) tick();
    chk_cnt++; if (fault !== 1'b1) $display("FAIL fault_sticky: got %b want 1", fault); else pass_cnt++;
    up_m = 1'b1;
    repeat (6) tick();
    chk_cnt++; if (position !== PW'(3)) $display("FAIL fault_pos_frozen: got %0d want 3", position); else pass_cnt++;
    up_m = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_cnt++; if (fault !== 1'b0 || position !== '0) $display("FAIL fault_clear: got fault %b pos %0d want fault 0 pos 0", fault, position); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    up_m = 1'b1;
    repeat (20) tick();
    chk_cnt++; if (position !== PW'(5) || moving !== 1'b1) $display("FAIL mid_pos: got pos %0d moving %b want pos 5 moving 1", position, moving); else pass_cnt++;
    reset = 1'b1;
    tick();
    chk_cnt++;
    if (position !== '0 || dn_max !== 1'b1 || moving !== 1'b0 || state_dbg !== 2'd0)
      $display("FAIL mid_reset: got pos %0d dn_max %b moving %b state %0d want 0 1 0 0", position, dn_max, moving, state_dbg);
    else pass_cnt++;
    reset = 1'b0; up_m = 1'b0;
    tick();
  endtask

`ifdef GARAGE_OBSTRUCT_EN
  task automatic test_obstruct();
    up_m = 1'b1;
    repeat (33) tick();
    up_m = 1'b0; dn_m = 1'b1;
    repeat (6) tick();
    chk_cnt++; if (position !== PW'(7)) $display("FAIL obs_pre: got %0d want 7", position); else pass_cnt++;
    obstruct = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk_cnt++;
      if (position !== PW'(7) || moving !== 1'b1) $display("FAIL obs_hold edge %0d: got pos %0d moving %b want 7 1", i, position, moving);
      else pass_cnt++;
    end
    obstruct = 1'b0;
    tick();
    chk_cnt++; if (position !== PW'(7)) $display("FAIL obs_resume1: got %0d want 7", position); else pass_cnt++;
    tick();
    chk_cnt++; if (position !== PW'(6)) $display("FAIL obs_resume2: got %0d want 6", position); else pass_cnt++;
    dn_m = 1'b0;
    tick();
  endtask
`endif

  // Random command runs with occasional resets. The scoreboard holds one
  // expected output vector per edge.
  task automatic test_random();
    int run_len;
    int cmd;
    logic [VW-1:0] exp_v, got_v;
    run_len = 0; cmd = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run_len == 0) begin
        run_len = $urandom_range(1, 45);
        cmd = $urandom_range(0, 40);
      end
      run_len--;
      up_m = (cmd < 18) || (cmd == 40);
      dn_m = (cmd >= 18 && cmd < 36) || (cmd == 40);
      reset = ($urandom_range(0, 99) < 2);
      obstruct = ($urandom_range(0, 9) < 3);
      tick();
      exp_q.push_back(model_vec());
      got_v = {position, up_max, dn_max, moving, fault};
      exp_v = exp_q.pop_front();
      chk_cnt++;
      if (got_v !== exp_v) $display("FAIL random cycle %0d: got pos/up/dn/mv/flt %h want %h", i, got_v, exp_v);
      else pass_cnt++;
      chk_cnt++;
      if (up_max && dn_max) $display("FAIL random_limits cycle %0d: got both limits 1 want at most one", i);
      else pass_cnt++;
    end
    reset = 1'b0; up_m = 1'b0; dn_m = 1'b0; obstruct = 1'b0;
  endtask

  initial begin
    test_reset();
    test_open();
    test_close_gap();
    test_fault();
    test_reset_mid();
`ifdef GARAGE_OBSTRUCT_EN
    test_obstruct();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
